// File: rtl/lstm_state_seq.sv
// LSTM sequence state holder: captures c_next/h_t per timestep, feeds them back
// as c_prev/h_prev and streams h out one element per valid/ready handshake.
module lstm_state_seq #(
   parameter int VEC_SIZE = 100,
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [CNT_W-1:0]             seq_len,
   input  logic                         step_valid,
   output logic                         step_ready,
   input  logic [VEC_SIZE*DATA_W-1:0]   c_next,
   input  logic [VEC_SIZE*DATA_W-1:0]   h_t,
   output logic [VEC_SIZE*DATA_W-1:0]   c_prev,
   output logic [VEC_SIZE*DATA_W-1:0]   h_prev,
   output logic [DATA_W-1:0]            h_out_data,
   output logic                         h_out_valid,
   input  logic                         h_out_ready,
   output logic                         h_out_last,
   output logic [CNT_W-1:0]             step_cnt,
   output logic                         busy,
   output logic                         done
);

   localparam int IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_STREAM,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] c_prev_q [VEC_SIZE];
   logic [DATA_W-1:0] c_prev_d [VEC_SIZE];
   logic [DATA_W-1:0] h_prev_q [VEC_SIZE];
   logic [DATA_W-1:0] h_prev_d [VEC_SIZE];
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_inc;

   logic start_acc;
   logic cap;
   logic hs;
   logic last_hs;

   assign start_acc = (state_q == S_IDLE) && start;
   assign cap       = (state_q == S_WAIT) && step_valid;
   assign hs        = (state_q == S_STREAM) && h_out_ready;
   assign last_hs   = hs && (idx_q == IDX_LAST);
   assign cnt_inc   = cnt_q + CNT_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (seq_len == '0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (step_valid) begin
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (last_hs) begin
               state_d = (cnt_inc == len_q) ? S_DONE : S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      step_ready  = 1'b0;
      h_out_valid = 1'b0;
      h_out_last  = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_WAIT: begin
            step_ready = 1'b1;
         end
         S_STREAM: begin
            h_out_valid = 1'b1;
            h_out_last  = (idx_q == IDX_LAST);
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Whole-vector capture happens in one edge so c/h stay a coherent pair.
   always_comb begin
      c_prev_d = c_prev_q;
      h_prev_d = h_prev_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      if (start_acc) begin
         for (int k = 0; k < VEC_SIZE; k++) begin
            c_prev_d[k] = '0;
            h_prev_d[k] = '0;
         end
         cnt_d = '0;
         len_d = seq_len;
      end
      if (cap) begin
         for (int k = 0; k < VEC_SIZE; k++) begin
            c_prev_d[k] = c_next[k*DATA_W +: DATA_W];
            h_prev_d[k] = h_t[k*DATA_W +: DATA_W];
         end
         idx_d = '0;
      end
      if (hs) begin
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            cnt_d = cnt_inc;
         end else begin
            idx_d = idx_q + IDX_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < VEC_SIZE; k++) begin
            c_prev_q[k] <= '0;
            h_prev_q[k] <= '0;
         end
         idx_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         c_prev_q <= c_prev_d;
         h_prev_q <= h_prev_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
      end
   end

   for (genvar g = 0; g < VEC_SIZE; g++) begin : g_flat
      assign c_prev[g*DATA_W +: DATA_W] = c_prev_q[g];
      assign h_prev[g*DATA_W +: DATA_W] = h_prev_q[g];
   end

   assign h_out_data = h_prev_q[idx_q];
   assign step_cnt   = cnt_q;

endmodule
